// File: rtl/ins_sequencer.sv
// ins_sequencer: fetch/decode/execute/writeback instruction sequencer.
//
// Ports:
//   clk, reset       rising-edge clock, synchronous active-high reset
//   run              allows a new instruction to start (sampled in IDLE and WB)
//   mem_ready        ins_word is valid during FETCH
//   ins_word[15:0]   instruction word from memory
//   alu_done         multi-cycle ALU operation finished (looked at only in EXEC)
//   pc[15:0]         fetch address
//   mem_req          fetch request (high in FETCH)
//   ir[15:0]         latched instruction
//   state[2:0]       IDLE=0 FETCH=1 DECODE=2 EXEC=3 WB=4 HALT=5
//   alu_start        one-cycle ALU launch (DECODE of an ALU-class op)
//   reg_we           register-file write enable (WB of an ALU-class op)
//   ins_done         one-cycle retire pulse (WB)
//   halted           sequencer stopped (HALT)
//   fetch_err        sticky fetch timeout flag
//
// Build option: define VR16_FETCH_TIMEOUT_EN to halt with fetch_err after
// TIMEOUT_CYCLES stalled FETCH cycles. Without it FETCH waits forever and
// fetch_err is tied to 0.
module ins_sequencer #(
  parameter logic [15:0] RESET_PC       = 16'h0000,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic        mem_ready,
  input  logic [15:0] ins_word,
  input  logic        alu_done,
  output logic [15:0] pc,
  output logic        mem_req,
  output logic [15:0] ir,
  output logic [2:0]  state,
  output logic        alu_start,
  output logic        reg_we,
  output logic        ins_done,
  output logic        halted,
  output logic        fetch_err
);

  localparam int unsigned CNT_W = 16;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  state_t      r_state;
  logic [15:0] r_pc;
  logic [15:0] r_ir;
  logic        r_mem_req;
  logic        r_alu_start;
  logic        r_reg_we;
  logic        r_ins_done;
  logic        r_halted;

  // Opcode classes of the latched instruction
  logic w_is_alu;
  logic w_is_jmp;
  logic w_is_halt;
  assign w_is_alu  = ~r_ir[15];
  assign w_is_jmp  = (r_ir[15:12] == 4'hE);
  assign w_is_halt = (r_ir[15:12] == 4'hF);

`ifdef VR16_FETCH_TIMEOUT_EN
  logic [CNT_W-1:0] r_tmo_cnt;
  logic             r_fetch_err;
`else
  logic w_unused_cfg;
  assign w_unused_cfg = (TIMEOUT_CYCLES == 0) || (CNT_W == 0);
`endif

  // Sequencer: outputs are registered alongside the state they belong to,
  // so each transition also loads the Moore outputs of the target state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_pc        <= RESET_PC;
      r_ir        <= 16'h0000;
      r_mem_req   <= 1'b0;
      r_alu_start <= 1'b0;
      r_reg_we    <= 1'b0;
      r_ins_done  <= 1'b0;
      r_halted    <= 1'b0;
`ifdef VR16_FETCH_TIMEOUT_EN
      r_tmo_cnt   <= '0;
      r_fetch_err <= 1'b0;
`endif
    end else begin
      r_mem_req   <= 1'b0;
      r_alu_start <= 1'b0;
      r_reg_we    <= 1'b0;
      r_ins_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (run) begin
            r_state   <= S_FETCH;
            r_mem_req <= 1'b1;
`ifdef VR16_FETCH_TIMEOUT_EN
            r_tmo_cnt <= '0;
`endif
          end
        end
        S_FETCH: begin
          if (mem_ready) begin
            r_ir        <= ins_word;
            r_pc        <= r_pc + 16'd1;
            r_state     <= S_DECODE;
            r_alu_start <= ~ins_word[15];
          end else begin
`ifdef VR16_FETCH_TIMEOUT_EN
            // This stalled cycle is the TIMEOUT_CYCLES-th one
            if (r_tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
              r_state     <= S_HALT;
              r_halted    <= 1'b1;
              r_fetch_err <= 1'b1;
            end else begin
              r_tmo_cnt <= r_tmo_cnt + CNT_W'(1);
              r_mem_req <= 1'b1;
            end
`else
            r_mem_req <= 1'b1;
`endif
          end
        end
        S_DECODE: begin
          if (w_is_halt) begin
            r_state  <= S_HALT;
            r_halted <= 1'b1;
          end else if (w_is_alu) begin
            r_state <= S_EXEC;
          end else begin
            r_state    <= S_WB;
            r_ins_done <= 1'b1;
          end
        end
        S_EXEC: begin
          if (alu_done) begin
            r_state    <= S_WB;
            r_ins_done <= 1'b1;
            r_reg_we   <= 1'b1;
          end
        end
        S_WB: begin
          if (w_is_jmp) begin
            r_pc <= {4'h0, r_ir[11:0]};
          end
          if (run) begin
            r_state   <= S_FETCH;
            r_mem_req <= 1'b1;
`ifdef VR16_FETCH_TIMEOUT_EN
            r_tmo_cnt <= '0;
`endif
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_HALT: begin
          r_state <= S_HALT;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign pc        = r_pc;
  assign ir        = r_ir;
  assign state     = r_state;
  assign mem_req   = r_mem_req;
  assign alu_start = r_alu_start;
  assign reg_we    = r_reg_we;
  assign ins_done  = r_ins_done;
  assign halted    = r_halted;
`ifdef VR16_FETCH_TIMEOUT_EN
  assign fetch_err = r_fetch_err;
`else
  assign fetch_err = 1'b0;
`endif

endmodule

// File: tb/tb_ins_sequencer.sv
// Bench for ins_sequencer: directed program, retire scoreboard, latency,
// halt, reset-priority, pc wrap and fetch timeout checks.
module tb_ins_sequencer;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance (RESET_PC = 0)
  logic        reset, run, mem_ready, alu_done;
  logic [15:0] ins_word;
  logic [15:0] pc, ir;
  logic [2:0]  state;
  logic        mem_req, alu_start, reg_we, ins_done, halted, fetch_err;

  // Second instance (RESET_PC = 16'hFFFF)
  logic        reset2, run2, mem_ready2, alu_done2;
  logic [15:0] ins_word2;
  logic [15:0] pc2, ir2;
  logic [2:0]  state2;
  logic        mem_req2, alu_start2, reg_we2, ins_done2, halted2, fetch_err2;

  logic [15:0] mem [0:255];
  assign ins_word = mem[pc[7:0]];

  ins_sequencer dut (
    .clk(clk), .reset(reset), .run(run), .mem_ready(mem_ready),
    .ins_word(ins_word), .alu_done(alu_done), .pc(pc), .mem_req(mem_req),
    .ir(ir), .state(state), .alu_start(alu_start), .reg_we(reg_we),
    .ins_done(ins_done), .halted(halted), .fetch_err(fetch_err)
  );

  ins_sequencer #(.RESET_PC(16'hFFFF)) dut2 (
    .clk(clk), .reset(reset2), .run(run2), .mem_ready(mem_ready2),
    .ins_word(ins_word2), .alu_done(alu_done2), .pc(pc2), .mem_req(mem_req2),
    .ir(ir2), .state(state2), .alu_start(alu_start2), .reg_we(reg_we2),
    .ins_done(ins_done2), .halted(halted2), .fetch_err(fetch_err2)
  );

  typedef struct packed {
    logic [15:0] ir;
    logic        we;
    logic [15:0] pc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Monitor: every retire pulse is matched against the scoreboard head
  logic prev_done = 1'b0;
  exp_t mon_e;
  always @(negedge clk) begin
    if (reset) begin
      prev_done = 1'b0;
    end else begin
      if (ins_done === 1'b1) begin
        chk("ins_done_back_to_back", {31'b0, prev_done}, 32'd0);
        if (sb.size() == 0) begin
          chk("unexpected_ins_done", {31'b0, ins_done}, 32'd0);
        end else begin
          mon_e = sb.pop_front();
          chk("retire_ir", {16'b0, ir}, {16'b0, mon_e.ir});
          chk("retire_reg_we", {31'b0, reg_we}, {31'b0, mon_e.we});
          chk("retire_pc", {16'b0, pc}, {16'b0, mon_e.pc});
        end
      end
      prev_done = ins_done;
    end
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"}, {29'b0, state}, 32'd0);
    chk({tag, "_pc"}, {16'b0, pc}, 32'h0000);
    chk({tag, "_ir"}, {16'b0, ir}, 32'h0000);
    chk({tag, "_outs"}, {27'b0, mem_req, alu_start, reg_we, ins_done, halted}, 32'd0);
    chk({tag, "_fetch_err"}, {31'b0, fetch_err}, 32'd0);
  endtask

  // Wait (bounded) for the next retire; returns cycles taken and alu_start count
  task automatic wait_done(input string tag, output int cyc, output int alu_seen);
    bit got;
    got = 1'b0; cyc = 0; alu_seen = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      cyc++;
      if (alu_start) alu_seen++;
      if (ins_done) got = 1'b1;
    end
    if (!got) chk({tag, "_retire_timeout"}, {31'b0, ins_done}, 32'd1);
  endtask

  task automatic wait_state(input string tag, input logic [2:0] s);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (state == s) got = 1'b1;
    end
    if (!got) chk({tag, "_state_timeout"}, {29'b0, state}, {29'b0, s});
  endtask

  int cyc, al;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h8000;
    mem[8'h00] = 16'h1234;  // ALU
    mem[8'h01] = 16'h8001;  // non-ALU
    mem[8'h02] = 16'hE010;  // jump to 0x010
    mem[8'h10] = 16'hE0A5;  // jump to 0x0A5
    mem[8'hA5] = 16'h2000;  // ALU, slow alu_done
    mem[8'hA6] = 16'hF000;  // halt

    reset = 1'b1; run = 1'b0; mem_ready = 1'b1; alu_done = 1'b1;
    reset2 = 1'b1; run2 = 1'b0; mem_ready2 = 1'b1; alu_done2 = 1'b1;
    ins_word2 = 16'h8000;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");

    // Expected retire sequence of the directed program
    sb.push_back('{ir: 16'h1234, we: 1'b1, pc: 16'h0001});
    sb.push_back('{ir: 16'h8001, we: 1'b0, pc: 16'h0002});
    sb.push_back('{ir: 16'hE010, we: 1'b0, pc: 16'h0003});
    sb.push_back('{ir: 16'hE0A5, we: 1'b0, pc: 16'h0011});
    sb.push_back('{ir: 16'h2000, we: 1'b1, pc: 16'h00A6});

    reset = 1'b0; run = 1'b1;
    wait_done("alu1", cyc, al);
    chk("alu1_latency", cyc, 32'd4);
    chk("alu1_alu_start", al, 32'd1);
    wait_done("nonalu", cyc, al);
    chk("nonalu_latency", cyc, 32'd3);
    chk("nonalu_no_alu_start", al, 32'd0);
    wait_done("jmp1", cyc, al);
    chk("jmp1_latency", cyc, 32'd3);
    wait_done("jmp2", cyc, al);
    chk("jmp2_latency", cyc, 32'd3);
    chk("jmp2_no_alu_start", al, 32'd0);

    // Slow ALU op: alu_done low while fetching/decoding must be harmless
    alu_done = 1'b0;
    @(negedge clk);
    chk("jmp_fetch_state", {29'b0, state}, 32'd1);
    chk("jmp_fetch_pc", {16'b0, pc}, 32'h00A5);
    chk("jmp_fetch_mem_req", {31'b0, mem_req}, 32'd1);
    @(negedge clk);
    chk("slow_decode_alu_start", {31'b0, alu_start}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("slow_exec_state", {29'b0, state}, 32'd3);
      chk("slow_exec_no_done", {31'b0, ins_done}, 32'd0);
    end
    alu_done = 1'b1;
    wait_done("slow", cyc, al);
    chk("slow_wb_after_exec", cyc, 32'd1);

    // Halt instruction: no retire, sequencer parks
    wait_state("halt", 3'd5);
    repeat (3) @(negedge clk);
    chk("halt_state", {29'b0, state}, 32'd5);
    chk("halt_halted", {31'b0, halted}, 32'd1);
    chk("halt_mem_req", {31'b0, mem_req}, 32'd0);
    chk("halt_ins_done", {31'b0, ins_done}, 32'd0);
    chk("sb_drained", sb.size(), 32'd0);

    reset = 1'b1;
    @(negedge clk);
    chk_reset_vals("halt_reset");

    // Reset with run high while stuck in EXEC
    reset = 1'b0; alu_done = 1'b0;
    wait_state("midexec", 3'd3);
    reset = 1'b1;
    @(negedge clk);
    chk_reset_vals("midexec_reset");
    alu_done = 1'b1;

    // Fetch with mem_ready held low
    mem_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (16) @(negedge clk);
    chk("tmo_still_fetch", {29'b0, state}, 32'd1);
    @(negedge clk);
`ifdef VR16_FETCH_TIMEOUT_EN
    chk("tmo_state", {29'b0, state}, 32'd5);
    chk("tmo_fetch_err", {31'b0, fetch_err}, 32'd1);
    chk("tmo_mem_req", {31'b0, mem_req}, 32'd0);
`else
    chk("tmo_state", {29'b0, state}, 32'd1);
    chk("tmo_fetch_err", {31'b0, fetch_err}, 32'd0);
    chk("tmo_mem_req", {31'b0, mem_req}, 32'd1);
`endif
    reset = 1'b1; run = 1'b0; mem_ready = 1'b1;
    @(negedge clk);
    chk("tmo_reset_fetch_err", {31'b0, fetch_err}, 32'd0);

    // Second instance: RESET_PC = FFFF wraps on fetch
    chk("wrap_reset_pc", {16'b0, pc2}, 32'hFFFF);
    chk("wrap_reset_state", {29'b0, state2}, 32'd0);
    reset2 = 1'b0; run2 = 1'b1;
    @(negedge clk);
    chk("wrap_fetch_pc", {16'b0, pc2}, 32'hFFFF);
    run2 = 1'b0;
    @(negedge clk);
    chk("wrap_decode_pc", {16'b0, pc2}, 32'h0000);
    @(negedge clk);
    chk("wrap_wb_done", {31'b0, ins_done2}, 32'd1);
    chk("wrap_wb_reg_we", {31'b0, reg_we2}, 32'd0);
    @(negedge clk);
    chk("wrap_idle_state", {29'b0, state2}, 32'd0);
    chk("wrap_idle_done", {31'b0, ins_done2}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ins_sequencer.md
INS_SEQUENCER -- requirements
Module: ins_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000, meaning the PC value loaded on reset.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 16, meaning the fetch wait limit used only when VR16_FETCH_TIMEOUT_EN is defined.
REQ-003 SHALL use one clock and a synchronous, active-high reset.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 run  input  1  enables instruction issue.
REQ-007 mem_ready  input  1  instruction word valid this cycle.
REQ-008 ins_word  input  16  instruction word from memory.
REQ-009 alu_done  input  1  multi-cycle ALU operation complete.
REQ-010 pc  output  16  fetch address.
REQ-011 mem_req  output  1  fetch request.
REQ-012 ir  output  16  latched instruction.
REQ-013 state  output  3  encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, WB=4, HALT=5.
REQ-014 alu_start  output  1  one-cycle ALU launch.
REQ-015 reg_we  output  1  register-file write enable.
REQ-016 ins_done  output  1  one-cycle retire pulse, consumed by control_unit.
REQ-017 halted  output  1  sequencer stopped.
REQ-018 fetch_err  output  1  sticky fetch timeout flag.

Function
REQ-019 Outputs mem_req, alu_start, reg_we, ins_done and halted SHALL be decoded from state only (Moore).
REQ-020 IDLE: mem_req=0; SHALL go to FETCH when run=1, else remain in IDLE.
REQ-021 FETCH: mem_req=1 and pc holds the address; on mem_ready=1 SHALL set ir<=ins_word and pc<=pc+1 (16'hFFFF wraps to 16'h0000), then go to DECODE; otherwise SHALL wait.
REQ-022 DECODE (one cycle): opcode ir[15:12]=4'hF SHALL go to HALT; opcodes 4'h0-4'h7 (ALU class) SHALL assert alu_start for this cycle and go to EXEC; opcodes 4'h8-4'hE SHALL go to WB.
REQ-023 EXEC: SHALL wait until alu_done=1, then go to WB; alu_done SHALL be ignored in all other states.
REQ-024 WB (one cycle): SHALL assert ins_done=1; SHALL assert reg_we=1 only for ALU class; for opcode 4'hE (jump) SHALL load pc<={4'h0, ir[11:0]}.
REQ-025 From WB SHALL go to FETCH if run=1, else IDLE; run SHALL be sampled only in IDLE and WB, so deassertion mid-instruction completes the instruction.
REQ-026 HALT: halted=1, mem_req=0; SHALL remain in HALT until reset.
REQ-027 Minimum latency with mem_ready and alu_done already high SHALL be 4 cycles per ALU instruction and 3 cycles per non-ALU instruction, with back-to-back issue and no idle cycle between instructions.
REQ-028 ins_done SHALL never be high for two consecutive cycles.

Reset
REQ-029 Reset SHALL take priority over every transition, including mid-FETCH and mid-EXEC.
REQ-030 On reset, outputs and internal state SHALL be: state=IDLE, pc=RESET_PC, ir=16'h0000, mem_req=0, alu_start=0, reg_we=0, ins_done=0, halted=0, fetch_err=0, timeout counter=0.

Configuration
REQ-031 With VR16_FETCH_TIMEOUT_EN defined, a counter SHALL clear on entry to FETCH and count FETCH cycles with mem_ready=0.
REQ-032 With VR16_FETCH_TIMEOUT_EN defined, when the counter reaches TIMEOUT_CYCLES the sequencer SHALL go to HALT and set fetch_err=1, which stays set until reset.
REQ-033 Without VR16_FETCH_TIMEOUT_EN, FETCH SHALL wait indefinitely, and the fetch_err port SHALL remain present and tied to 0.

Verification
REQ-034 reset, run=1, mem_ready=1, ins_word=16'h1234, alu_done=1 -> ins_done pulses at cycle 4, reg_we=1 in the same cycle, pc=16'h0001.
REQ-035 ins_word=16'hE0A5 at pc=16'h0010 -> no alu_start, ins_done at cycle 3, next fetch pc=16'h00A5.
REQ-036 ALU op with alu_done held low 5 cycles -> state stays EXEC for 5 cycles, then a single ins_done pulse.
REQ-037 ins_word=16'hF000 -> halted=1, no ins_done, mem_req=0 thereafter; reset -> IDLE with pc=RESET_PC.
REQ-038 RESET_PC=16'hFFFF, one non-ALU fetch -> pc=16'h0000; a separate run asserted during reset in mid-EXEC -> IDLE, all outputs at their reset values.
REQ-039 VR16_FETCH_TIMEOUT_EN defined, mem_ready=0 for 16 cycles -> HALT with fetch_err=1; without the macro, the same stimulus leaves state=FETCH and fetch_err=0.
